// File: rtl/dll_code_tracker.sv
// Post-acquisition delay-code tracker: loads the SAR result, then nudges the code by +/-1 LSB
// from majority-filtered PD decisions. Optional lock detector guarded by DLL_TRACK_LOCK_DETECT_EN.
module dll_code_tracker #(
  parameter int VOTE_TH  = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic       clk_ext,
  input  logic       rst,
  input  logic       sar_done,
  input  logic [9:0] sar_q,
  input  logic       comp_valid,
  input  logic       comp,
  input  logic       freeze,
  output logic [9:0] code_out,
  output logic       code_valid,
  output logic       locked
);

  localparam int VW = $clog2(VOTE_TH) + 2;
  localparam logic signed [VW-1:0] V_POS = VW'(VOTE_TH);
  localparam logic signed [VW-1:0] V_NEG = -V_POS;
  localparam logic signed [VW-1:0] V_ONE = VW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, TRACK, HOLD} state_t;

  state_t               state, state_next;
  logic                 sar_done_q;
  logic                 sar_rise;
  logic signed [VW-1:0] votes, votes_next, vote_try;
  logic                 step_up, step_dn, step_any, suppressed;

  assign sar_rise   = sar_done & ~sar_done_q;
  assign vote_try   = comp ? (votes + V_ONE) : (votes - V_ONE);
  assign code_valid = (state == TRACK) || (state == HOLD);
  assign step_any   = step_up | step_dn;
  // A step that would run off either end of the code range is swallowed but still counts as a step.
  assign suppressed = (step_up && (code_out == 10'd1023)) || (step_dn && (code_out == 10'd0));

  always_comb begin
    state_next = state;
    votes_next = votes;
    step_up    = 1'b0;
    step_dn    = 1'b0;
    case (state)
      IDLE: if (sar_done) state_next = LOAD;
      LOAD: begin
        state_next = TRACK;
        votes_next = '0;
      end
      TRACK: begin
        if (sar_rise) begin
          state_next = LOAD;
        end else if (freeze) begin
          state_next = HOLD;
        end else if (comp_valid) begin
          if (vote_try == V_POS) begin
            step_up    = 1'b1;
            votes_next = '0;
          end else if (vote_try == V_NEG) begin
            step_dn    = 1'b1;
            votes_next = '0;
          end else begin
            votes_next = vote_try;
          end
        end
      end
      HOLD: begin
        if (sar_rise) state_next = LOAD;
        else if (!freeze) state_next = TRACK;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state      <= IDLE;
      votes      <= '0;
      sar_done_q <= 1'b0;
      code_out   <= 10'd0;
    end else begin
      state      <= state_next;
      votes      <= votes_next;
      sar_done_q <= sar_done;
      if (state == LOAD) code_out <= sar_q;
      else if (step_up && !suppressed) code_out <= code_out + 10'd1;
      else if (step_dn && !suppressed) code_out <= code_out - 10'd1;
    end
  end

`ifdef DLL_TRACK_LOCK_DETECT_EN
  localparam logic [7:0] LCNT = 8'(LOCK_CNT);

  logic       dir_up, have_dir;
  logic [7:0] rev_cnt, rev_next;

  // Reversals count only once a previous direction exists; the first step after LOAD just seeds it.
  always_comb begin
    rev_next = rev_cnt;
    if (state == LOAD) begin
      rev_next = 8'd0;
    end else if (step_any) begin
      if (suppressed) rev_next = 8'd0;
      else if (!have_dir) rev_next = rev_cnt;
      else if (step_up != dir_up) rev_next = (rev_cnt == LCNT) ? LCNT : rev_cnt + 8'd1;
      else rev_next = 8'd0;
    end
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      dir_up   <= 1'b1;
      have_dir <= 1'b0;
      rev_cnt  <= 8'd0;
      locked   <= 1'b0;
    end else begin
      rev_cnt <= rev_next;
      locked  <= (rev_next == LCNT);
      if (state == LOAD) begin
        have_dir <= 1'b0;
      end else if (step_any) begin
        have_dir <= 1'b1;
        dir_up   <= step_up;
      end
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_dll_code_tracker.sv
// Directed bench for dll_code_tracker (VOTE_TH=4, LOCK_CNT=8); lock expectations follow DLL_TRACK_LOCK_DETECT_EN.
module tb_dll_code_tracker;

`ifdef DLL_TRACK_LOCK_DETECT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk_ext = 1'b0;
  logic       rst = 1'b1;
  logic       sar_done = 1'b0;
  logic [9:0] sar_q = 10'd0;
  logic       comp_valid = 1'b0;
  logic       comp = 1'b0;
  logic       freeze = 1'b0;
  logic [9:0] code_out;
  logic       code_valid;
  logic       locked;

  int checks = 0;
  int errors = 0;

  dll_code_tracker #(.VOTE_TH(4), .LOCK_CNT(8)) dut (
    .clk_ext(clk_ext), .rst(rst), .sar_done(sar_done), .sar_q(sar_q),
    .comp_valid(comp_valid), .comp(comp), .freeze(freeze),
    .code_out(code_out), .code_valid(code_valid), .locked(locked)
  );

  always #5 clk_ext = ~clk_ext;

  task automatic tick();
    @(posedge clk_ext);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic c);
    comp_valid = 1'b1;
    comp = c;
    tick();
    comp_valid = 1'b0;
  endtask

  task automatic votes4(input logic c);
    for (int i = 0; i < 4; i++) strobe(c);
  endtask

  // Falling then rising sar_done; code must appear two edges after the rise.
  task automatic reload(input logic [9:0] val);
    sar_done = 1'b0;
    tick();
    sar_q = val;
    sar_done = 1'b1;
    tick();
    check("load_valid_low", int'(code_valid), 0);
    tick();
    check("load_code", int'(code_out), int'(val));
    check("load_valid", int'(code_valid), 1);
    check("load_locked", int'(locked), 0);
  endtask

  initial begin
    tick();
    tick();
    check("rst_code", int'(code_out), 0);
    check("rst_valid", int'(code_valid), 0);
    check("rst_locked", int'(locked), 0);
    rst = 1'b0;
    tick();
    check("idle_valid", int'(code_valid), 0);

    // Initial acquisition at 512, sar_done then held high.
    reload(10'd512);
    for (int i = 0; i < 3; i++) strobe(1'b1);
    check("three_votes_no_step", int'(code_out), 512);
    strobe(1'b1);
    check("fourth_vote_step", int'(code_out), 513);

    // Upper clamp, then votes must be cleared so four downs step.
    reload(10'd1023);
    votes4(1'b1);
    check("clamp_hi", int'(code_out), 1023);
    check("clamp_hi_locked", int'(locked), 0);
    for (int i = 0; i < 3; i++) strobe(1'b0);
    check("clamp_hi_votes_pending", int'(code_out), 1023);
    strobe(1'b0);
    check("clamp_hi_votes_cleared", int'(code_out), 1022);

    // Lower clamp.
    reload(10'd0);
    votes4(1'b0);
    check("clamp_lo", int'(code_out), 0);
    check("clamp_lo_locked", int'(locked), 0);
    for (int i = 0; i < 3; i++) strobe(1'b1);
    check("clamp_lo_votes_pending", int'(code_out), 0);
    strobe(1'b1);
    check("clamp_lo_votes_cleared", int'(code_out), 1);

    // Lock: nine alternating steps starting up.
    reload(10'd512);
    for (int k = 1; k <= 9; k++) begin
      votes4(k % 2 == 1);
      check($sformatf("alt_code_%0d", k), int'(code_out), (k % 2 == 1) ? 513 : 512);
      check($sformatf("alt_locked_%0d", k), int'(locked), int'(LOCK_EN && k == 9));
    end
    votes4(1'b0);
    check("down1_code", int'(code_out), 512);
    check("down1_locked", int'(locked), int'(LOCK_EN));
    votes4(1'b0);
    check("down2_code", int'(code_out), 511);
    check("down2_locked", int'(locked), 0);
    for (int k = 12; k <= 19; k++) begin
      votes4(k % 2 == 0);
      check($sformatf("relock_code_%0d", k), int'(code_out), (k % 2 == 0) ? 512 : 511);
      check($sformatf("relock_locked_%0d", k), int'(locked), int'(LOCK_EN && k == 19));
    end

    // Freeze with votes at +2; the vote on the freeze cycle is discarded.
    strobe(1'b1);
    strobe(1'b1);
    freeze = 1'b1;
    strobe(1'b1);
    for (int i = 0; i < 10; i++) strobe(1'b0);
    check("hold_code", int'(code_out), 511);
    check("hold_valid", int'(code_valid), 1);
    check("hold_locked", int'(locked), int'(LOCK_EN));
    freeze = 1'b0;
    tick();
    strobe(1'b1);
    check("unfreeze_vote3", int'(code_out), 511);
    strobe(1'b1);
    check("unfreeze_step", int'(code_out), 512);
    check("unfreeze_locked", int'(locked), int'(LOCK_EN));

    // Re-acquisition while locked.
    reload(10'd100);
    tick();
    check("no_reload_on_level", int'(code_out), 100);

    // Reset in the middle of tracking, then IDLE ignores votes.
    strobe(1'b1);
    strobe(1'b1);
    rst = 1'b1;
    tick();
    check("midrst_code", int'(code_out), 0);
    check("midrst_valid", int'(code_valid), 0);
    check("midrst_locked", int'(locked), 0);
    sar_done = 1'b0;
    rst = 1'b0;
    votes4(1'b1);
    check("idle_ignores_code", int'(code_out), 0);
    check("idle_ignores_valid", int'(code_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dll_code_tracker.md
# dll_code_tracker

Post-acquisition delay-code tracker for the FMDLL. It sits directly downstream of the 10-bit SAR. Once binary search completes, it loads the SAR result and continuously re-trims the delay-line code by ±1 LSB from filtered phase-detector COMP decisions. It also reports lock status. Its 10-bit output replaces the raw SAR word as the source for the 4-to-16 decoder and the fine-code path.

## Interface
Parameters:
- VOTE_TH, 4: majority-filter threshold (≥2); a step occurs after a net VOTE_TH same-sign decisions.
- LOCK_CNT, 8: consecutive alternating steps required to assert locked (≥2, ≤255).

Ports:
- clk_ext  in  1  reference clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- sar_done  in  1  level; high when the SAR has converged and sar_q is stable.
- sar_q  in  10  SAR result code.
- comp_valid  in  1  one-cycle strobe; comp is meaningful this cycle.
- comp  in  1  PD decision: 1 = delay too short (increase code), 0 = too long (decrease).
- freeze  in  1  level; holds code and filter state.
- code_out  out  10  tracked delay code.
- code_valid  out  1  high in TRACK and HOLD.
- locked  out  1  lock indicator.

## Operation
- States: IDLE, LOAD, TRACK, HOLD.
- IDLE: ignores comp_valid; on sar_done=1 → LOAD.
- LOAD: latches code_out<=sar_q, clears votes and the reversal count, and sets locked=0 → TRACK.
- TRACK:
  - comp_valid with comp=1 gives votes+1; comp=0 gives votes−1.
  - Votes are a signed counter in (−VOTE_TH, +VOTE_TH).
  - When the updated value would reach +VOTE_TH, step up: code_out+1, votes←0.
  - When it would reach −VOTE_TH, step down: code_out−1, votes←0.
- Saturation: code_out clamps at 0 and 1023. A suppressed step still clears votes and is treated as a same-direction step for lock purposes.
- Lock detection: tracks the previous step direction.
  - A step opposite to the previous one increments the reversal count, saturating at LOCK_CNT.
  - A step in the same direction, or a suppressed step, clears the count and drops locked.
  - locked=1 while the count equals LOCK_CNT.
  - The first step after LOAD sets the direction only and does not count.
- freeze=1 in TRACK → HOLD. In HOLD, comp_valid is ignored and code, votes, count and locked are retained. freeze=0 → TRACK.
- sar_done rising (0→1) while in TRACK or HOLD → LOAD (re-acquisition). sar_done staying high does not reload.
- Priority: rst > sar_done rising > freeze > comp_valid.

## Timing
- Reset values: state=IDLE, code_out=10'd0, code_valid=0, locked=0, votes=0, count=0, direction=up.
- sar_done sampled high in IDLE → LOAD next cycle → code_out=sar_q and code_valid=1 on the following cycle, i.e. 2 cycles after sar_done.
- Step latency: a code change is visible 1 cycle after the comp_valid that reaches threshold.
- locked rises/falls in the same cycle as the qualifying code_out update.
- Back-to-back comp_valid every cycle is supported; there is at most one step per cycle.
- rst asserted mid-TRACK returns all outputs to reset values on the next edge.
- freeze and comp_valid in the same cycle: freeze wins and the vote is discarded.

## Configuration
- DLL_TRACK_LOCK_DETECT_EN defined: the reversal counter, direction register and locked output logic are built as described.
- Not defined: the lock logic is removed, locked is tied to 0, and code tracking is unchanged.

## Test plan
- Reset, then sar_done=1 with sar_q=10'd512 → code_out=512 and code_valid=1 two cycles later; locked=0.
- Four comp_valid strobes with comp=1 (VOTE_TH=4) → code_out=513 one cycle after the fourth; three strobes → no change.
- sar_q=1023, then 4×comp=1 → code_out stays 1023, votes clear, locked stays 0. Same at 0 with comp=0.
- Alternate 4×comp=1 / 4×comp=0 for 9 steps (LOCK_CNT=8) → locked=1 at the 9th step. Then two consecutive down-steps → locked=0 on the second.
- freeze=1 mid-vote (votes=+2), apply 10 comp=0 strobes, release, then 2×comp=1 → code_out increments (votes were retained at +2).
- sar_done 0→1 in TRACK with sar_q=100 while locked=1 → locked=0 and code_out=100 two cycles later. Without DLL_TRACK_LOCK_DETECT_EN, locked is 0 throughout all scenarios.
